// File: rtl/axi_mem_responder_if.sv
// AXI-style memory responder bus bundle.
// Carries the five channels between a master and the responder:
//   AW: AWVALID/AWREADY/AWID/AWLEN/AWADDR
//   W : WVALID/WREADY/WLAST/WID/WDATA
//   B : BVALID/BREADY/BID
//   AR: ARVALID/ARREADY/ARID/ARLEN/ARADDR
//   R : RVALID/RREADY/RLAST/RID/RDATA
// master modport drives requests; slave modport is the responder side.
interface axi_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [3:0]            AWID;
  logic [3:0]            AWLEN;
  logic [ADDR_WIDTH-1:0] AWADDR;

  logic                  WVALID;
  logic                  WREADY;
  logic                  WLAST;
  logic [3:0]            WID;
  logic [DATA_WIDTH-1:0] WDATA;

  logic                  BVALID;
  logic                  BREADY;
  logic [3:0]            BID;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [3:0]            ARID;
  logic [3:0]            ARLEN;
  logic [ADDR_WIDTH-1:0] ARADDR;

  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;
  logic [3:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;

  modport master (
    output AWVALID, AWID, AWLEN, AWADDR, input AWREADY,
    output WVALID, WLAST, WID, WDATA,    input WREADY,
    input  BVALID, BID,                  output BREADY,
    output ARVALID, ARID, ARLEN, ARADDR, input ARREADY,
    input  RVALID, RLAST, RID, RDATA,    output RREADY
  );

  modport slave (
    input  AWVALID, AWID, AWLEN, AWADDR, output AWREADY,
    input  WVALID, WLAST, WID, WDATA,    output WREADY,
    output BVALID, BID,                  input BREADY,
    input  ARVALID, ARID, ARLEN, ARADDR, output ARREADY,
    output RVALID, RLAST, RID, RDATA,    input RREADY
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI-style burst memory responder.
// Backing store of 2^DEPTH_LOG2 words; independent read and write FSMs.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (array contents are not reset)
//   bus   - axi_mem_responder_if.slave (AW/W/B/AR/R channels)
// Reads: first RVALID READ_LATENCY cycles after the AR handshake, LEN+1 beats.
// Writes: beat count from AWLEN only; WLAST/WID are ignored.
module axi_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 14,
  parameter int READ_LATENCY = 4
) (
  input logic               clk,
  input logic               rst_n,
  axi_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  r_state_t              r_state;
  logic [3:0]            r_len, r_beat, r_cnt, rid;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic                  arready, rvalid, rlast;

  w_state_t              w_state;
  logic [3:0]            w_len, w_beat, bid;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic                  awready, wready, bvalid;

  // Upper address bits and WLAST/WID are intentionally not used.
  logic unused_inputs;
  assign unused_inputs = ^{bus.AWADDR, bus.ARADDR, bus.WLAST, bus.WID};

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (bus.ARVALID && arready) begin
            rid     <= bus.ARID;
            r_len   <= bus.ARLEN;
            r_addr  <= bus.ARADDR[DEPTH_LOG2-1:0];
            r_cnt   <= 4'(READ_LATENCY - 1);
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            rvalid  <= 1'b1;
            rlast   <= (r_len == 4'd0);
            r_beat  <= '0;
            r_state <= R_BURST;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_BURST: begin
          if (bus.RREADY) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_beat <= r_beat + 4'd1;
              rlast  <= (r_beat + 4'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_addr  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (bus.AWVALID && awready) begin
            bid     <= bus.AWID;
            w_len   <= bus.AWLEN;
            w_addr  <= bus.AWADDR[DEPTH_LOG2-1:0];
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.WVALID) begin
            w_addr <= w_addr + 1'b1;
            w_beat <= w_beat + 4'd1;
            if (w_beat == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array write port; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wready && bus.WVALID) mem[w_addr] <= bus.WDATA;
  end

  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RLAST   = rlast;
  assign bus.RID     = rid;
  // Combinational read gives read-before-write on a same-edge collision.
  assign bus.RDATA   = (r_state == R_BURST) ? mem[r_addr] : '0;
  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = bid;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default parameters).
module tb_axi_mem_responder;
  typedef logic [31:0] words_t [16];

  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  axi_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axi_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(14), .READ_LATENCY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr,
                          input words_t data, input bit gaps, input int bready_delay);
    int n;
    bus.AWVALID = 1'b1; bus.AWID = id; bus.AWLEN = len; bus.AWADDR = addr;
    n = 0;
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    check("aw_wait", 64'(n < 50), 1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && i[0]) begin bus.WVALID = 1'b0; @(negedge clk); end
      bus.WVALID = 1'b1; bus.WDATA = data[i]; bus.WLAST = (i == int'(len)); bus.WID = id;
      n = 0;
      while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
      check("w_wait", 64'(n < 50), 1);
      @(negedge clk);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check("bvalid", bus.BVALID, 1);
    check("bid", bus.BID, id);
    for (int d = 0; d < bready_delay; d++) begin
      check("bvalid_hold", bus.BVALID, 1);
      check("bid_hold", bus.BID, id);
      check("awready_in_resp", bus.AWREADY, 0);
      @(negedge clk);
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("bvalid_clr", bus.BVALID, 0);
    check("awready_back", bus.AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr,
                         input words_t exp, input logic [31:0] pat);
    int n, beat, cyc;
    logic took;
    bus.ARVALID = 1'b1; bus.ARID = id; bus.ARLEN = len; bus.ARADDR = addr; bus.RREADY = 1'b0;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    check("ar_wait", 64'(n < 50), 1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 40) begin @(negedge clk); n++; end
    check("r_latency", n, 4);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      took = pat[cyc % 32];
      bus.RREADY = took;
      check("rvalid", bus.RVALID, 1);
      check("rdata", bus.RDATA, exp[beat]);
      check("rlast", bus.RLAST, 64'(beat == int'(len)));
      check("rid", bus.RID, id);
      check("arready_busy", bus.ARREADY, 0);
      @(negedge clk);
      if (took) beat++;
      cyc++;
    end
    bus.RREADY = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("rvalid_end", bus.RVALID, 0);
    check("arready_end", bus.ARREADY, 1);
  endtask

  initial begin : stim
    words_t w;
    int n;
    bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
    bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WDATA = 0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0; bus.RREADY = 0;

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_awready", bus.AWREADY, 0);
    check("rst_wready", bus.WREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_bid", bus.BID, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_rdata", bus.RDATA, 0);
    @(negedge clk);
    check("rst_arready_clk", bus.ARREADY, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_arready_pre", bus.ARREADY, 0);
    check("rel_awready_pre", bus.AWREADY, 0);
    @(negedge clk);
    check("rel_arready", bus.ARREADY, 1);
    check("rel_awready", bus.AWREADY, 1);
    check("rel_wready", bus.WREADY, 0);

    // Single read of a preloaded word
    w = '{0: 32'hDEAD_BEEF, default: 32'h0};
    do_write(4'd1, 4'd0, 32'h10, w, 1'b0, 0);
    do_read(4'd3, 4'd0, 32'h10, w, '1);

    // Write burst with WVALID gaps and delayed BREADY, then read back
    w = '{0: 32'hA0, 1: 32'hA1, 2: 32'hA2, 3: 32'hA3, default: 32'h0};
    do_write(4'd5, 4'd3, 32'h20, w, 1'b1, 5);
    do_read(4'd6, 4'd3, 32'h20, w, '1);

    // Read backpressure: RREADY 1,0,0,1,0,0,...
    do_read(4'd2, 4'd3, 32'h20, w, 32'h4924_9249);

    // Wrap at top of array (write wraps too), with upper address bits set on read
    w = '{0: 32'h1111_FFFF, 1: 32'h2222_0000, default: 32'h0};
    do_write(4'd2, 4'd1, 32'h3FFF, w, 1'b0, 0);
    begin
      words_t wb;
      wb = '{0: 32'hB0, 1: 32'hB1, 2: 32'hB2, 3: 32'hB3, default: 32'h0};
      fork
        do_read(4'd4, 4'd1, 32'h0005_3FFF, w, '1);
        do_write(4'd9, 4'd3, 32'h100, wb, 1'b1, 0);
      join
      do_read(4'd10, 4'd3, 32'h100, wb, '1);
    end

    // Same-edge read beat and write beat to one word
    w = '{0: 32'h11, default: 32'h0};
    do_write(4'd7, 4'd0, 32'h40, w, 1'b0, 0);
    bus.ARVALID = 1'b1; bus.ARID = 4'd7; bus.ARLEN = 4'd0; bus.ARADDR = 32'h40;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 40) begin @(negedge clk); n++; end
    check("rbw_rvalid", bus.RVALID, 1);
    check("rbw_old_pre", bus.RDATA, 32'h11);
    bus.AWVALID = 1'b1; bus.AWID = 4'd8; bus.AWLEN = 4'd0; bus.AWADDR = 32'h40;
    n = 0;
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check("rbw_wready", bus.WREADY, 1);
    bus.WVALID = 1'b1; bus.WDATA = 32'h22; bus.RREADY = 1'b1;
    check("rbw_old_same", bus.RDATA, 32'h11);
    @(negedge clk);
    bus.WVALID = 1'b0; bus.RREADY = 1'b0;
    check("rbw_rvalid_end", bus.RVALID, 0);
    check("rbw_bvalid", bus.BVALID, 1);
    check("rbw_bid", bus.BID, 8);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    w = '{0: 32'h22, default: 32'h0};
    do_read(4'd7, 4'd0, 32'h40, w, '1);

    // Reset during beat 1 of a 4-beat read
    w = '{0: 32'hC0, 1: 32'hC1, 2: 32'hC2, 3: 32'hC3, default: 32'h0};
    do_write(4'd11, 4'd3, 32'h200, w, 1'b0, 0);
    bus.ARVALID = 1'b1; bus.ARID = 4'd12; bus.ARLEN = 4'd3; bus.ARADDR = 32'h200;
    n = 0;
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 40) begin @(negedge clk); n++; end
    check("mr_beat0", bus.RDATA, 32'hC0);
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    check("mr_beat1", bus.RDATA, 32'hC1);
    check("mr_rvalid1", bus.RVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_rvalid", bus.RVALID, 0);
    check("mr_rdata", bus.RDATA, 0);
    check("mr_rlast", bus.RLAST, 0);
    check("mr_rid", bus.RID, 0);
    check("mr_arready", bus.ARREADY, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_arready_pre", bus.ARREADY, 0);
    @(negedge clk);
    check("mr_arready_post", bus.ARREADY, 1);
    do_read(4'd13, 4'd3, 32'h200, w, '1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
